// File: rtl/rgb_mem_sequencer.sv
// rgb_mem_sequencer
//   Turns one decoded load/store into a req/ack bus transaction against the
//   RGB data memory. A single-channel access is one beat (sel = rgb). A packed
//   pixel access is three beats, with sel 00, 01, 10 in that order. The
//   pipeline is stalled until the transaction ends. Read bytes are assembled
//   into rdata_o. A beat that waits TIMEOUT cycles without an ack aborts the
//   transaction and flags an error.
//
// Handshake: bus_req_o and every bus_* field are held stable while in REQ.
//   A beat completes on the rising edge where bus_req_o=1 and bus_ack_i=1.
//   bus_rdata_i is sampled on that same edge.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   mem_read_i      load request from decoder
//   mem_write_i     store request from decoder (wins over mem_read_i)
//   rgb_i           00=R 01=G 10=B 11=packed pixel
//   addr_i          pixel address
//   wdata_i         store data; packed layout [7:0]R [15:8]G [23:16]B
//   stall_o         hold PC/pipeline
//   rdata_o         load result, zero-extended
//   rdata_valid_o   one-cycle pulse when rdata_o holds a completed load
//   err_o           one-cycle pulse on timeout abort
//   err_sticky_o    set by any timeout, cleared only by reset
//   bus_*           beat request/response
//   dbg_state_o     current FSM state (IDLE=0 REQ=1 DONE=2 ERR=3)
module rgb_mem_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [1:0]        rgb_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              err_o,
  output logic              err_sticky_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [1:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [7:0]        bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [7:0]        bus_rdata_i,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [23:0]         r_wdata;
  logic [1:0]          r_rgb;
  logic                r_we;
  logic [1:0]          r_beat;
  logic [WAIT_W-1:0]   r_wait;
  logic [23:0]         r_rdata;
  logic                r_err_sticky;

  logic                w_req_in;
  logic                w_last_beat;
  logic                w_timeout;
  logic [1:0]          w_sel;
  logic [7:0]          w_wbyte;

  assign w_req_in    = mem_read_i | mem_write_i;
  assign w_last_beat = (r_rgb != 2'b11) || (r_beat == 2'd2);
  assign w_sel       = (r_rgb == 2'b11) ? r_beat : r_rgb;
  // This no-ack cycle is the TIMEOUT-th one of the current beat.
  assign w_timeout   = (r_wait == WAIT_W'(TIMEOUT - 1));

  always_comb begin
    w_wbyte = 8'h00;
    case (w_sel)
      2'b00:   w_wbyte = r_wdata[7:0];
      2'b01:   w_wbyte = r_wdata[15:8];
      2'b10:   w_wbyte = r_wdata[23:16];
      default: w_wbyte = 8'h00;
    endcase
  end

  // Next state. An ack takes priority over a timeout in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_req_in) w_next = S_REQ;
      S_REQ: begin
        if (bus_ack_i) begin
          if (w_last_beat) w_next = S_DONE;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs. The IDLE stall depends on the request inputs and is gated by
  // rst_n, so every output is 0 while reset is asserted.
  always_comb begin
    stall_o       = 1'b0;
    bus_req_o     = 1'b0;
    bus_we_o      = 1'b0;
    bus_sel_o     = 2'b00;
    bus_addr_o    = '0;
    bus_wdata_o   = 8'h00;
    rdata_valid_o = 1'b0;
    err_o         = 1'b0;
    case (r_state)
      S_IDLE: stall_o = rst_n & w_req_in;
      S_REQ: begin
        stall_o     = 1'b1;
        bus_req_o   = 1'b1;
        bus_we_o    = r_we;
        bus_sel_o   = w_sel;
        bus_addr_o  = r_addr;
        bus_wdata_o = r_we ? w_wbyte : 8'h00;
      end
      S_DONE:  rdata_valid_o = ~r_we;
      S_ERR:   err_o = 1'b1;
      default: ;
    endcase
  end

  assign rdata_o      = DATA_W'(r_rdata);
  assign err_sticky_o = r_err_sticky;
  assign dbg_state_o  = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rgb        <= 2'b00;
      r_we         <= 1'b0;
      r_beat       <= 2'd0;
      r_wait       <= '0;
      r_rdata      <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_req_in) begin
            r_addr  <= addr_i;
            r_wdata <= wdata_i[23:0];
            r_rgb   <= rgb_i;
            r_we    <= mem_write_i;
            r_beat  <= 2'd0;
            r_wait  <= '0;
            r_rdata <= '0;
          end
        end
        S_REQ: begin
          if (bus_ack_i) begin
            if (!r_we) begin
              case (w_sel)
                2'b00:   r_rdata[7:0]   <= bus_rdata_i;
                2'b01:   r_rdata[15:8]  <= bus_rdata_i;
                2'b10:   r_rdata[23:16] <= bus_rdata_i;
                default: ;
              endcase
            end
            if (!w_last_beat) r_beat <= r_beat + 2'd1;
            r_wait <= '0;
          end else if (w_timeout) begin
            // Drop any partially assembled bytes so the aborted load reads 0.
            r_rdata <= '0;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_ERR:   r_err_sticky <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_mem_sequencer.sv
module tb_rgb_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read_i = 1'b0;
  logic        mem_write_i = 1'b0;
  logic [1:0]  rgb_i = 2'b00;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        err_o;
  logic        err_sticky_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [1:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [7:0]  bus_wdata_o;
  logic        bus_ack_i = 1'b0;
  logic [7:0]  bus_rdata_i = 8'h00;
  logic [1:0]  dbg_state_o;

  rgb_mem_sequencer #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .rgb_i(rgb_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .err_o(err_o), .err_sticky_o(err_sticky_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .dbg_state_o(dbg_state_o)
  );

  // Clock: posedges at 5,15,25...; inputs driven and outputs sampled at negedges.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Transaction observations.
  int          t_stall, t_valid, t_err, t_beats;
  logic [31:0] t_sel[3], t_wd[3], t_we[3], t_addr[3];
  logic [31:0] t_rdata, t_end_rdata, t_end_req;
  logic        t_done;

  // Issues one request, acts as the bus slave (beat k acked after d_k waiting
  // cycles with byte b_k), and runs until stall_o drops (DONE or ERR cycle).
  task automatic run_txn(input logic rd, input logic wr, input logic [1:0] rgb,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int d0, input int d1, input int d2,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int delay[3];
    logic [7:0] bytes[3];
    int w;
    int beat;
    delay[0] = d0; delay[1] = d1; delay[2] = d2;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    t_stall = 0; t_valid = 0; t_err = 0; t_rdata = '0;
    t_end_rdata = '0; t_end_req = '0; t_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      t_sel[i] = '1; t_wd[i] = '1; t_we[i] = '1; t_addr[i] = '1;
    end
    @(negedge clk);
    mem_read_i = rd; mem_write_i = wr; rgb_i = rgb; addr_i = addr; wdata_i = wdata;
    #1;
    if (stall_o) t_stall++;
    @(negedge clk);
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    w = 0;
    beat = 0;
    for (int c = 0; c < 100 && !t_done; c++) begin
      if (c > 0) @(negedge clk);
      bus_ack_i = 1'b0;
      if (rdata_valid_o) begin t_valid++; t_rdata = rdata_o; end
      if (err_o) t_err++;
      if (stall_o) t_stall++;
      if (!stall_o) begin
        t_done = 1'b1;
        t_end_rdata = rdata_o;
        t_end_req = {31'd0, bus_req_o};
      end else if (bus_req_o) begin
        if (beat < 3 && w == delay[beat]) begin
          bus_ack_i = 1'b1;
          bus_rdata_i = bytes[beat];
          t_sel[beat] = {30'd0, bus_sel_o};
          t_wd[beat] = {24'd0, bus_wdata_o};
          t_we[beat] = {31'd0, bus_we_o};
          t_addr[beat] = bus_addr_o;
          beat++;
          w = 0;
        end else begin
          w++;
        end
      end
    end
    bus_ack_i = 1'b0;
    t_beats = beat;
    check("txn_bound", {31'd0, t_done}, 32'd1);
  endtask

  // One cycle after the transaction: pulses gone, back in IDLE.
  task automatic check_after(input string tag, input logic exp_sticky);
    @(negedge clk);
    check({tag, "_valid_after"}, {31'd0, rdata_valid_o}, 32'd0);
    check({tag, "_err_after"}, {31'd0, err_o}, 32'd0);
    check({tag, "_sticky"}, {31'd0, err_sticky_o}, {31'd0, exp_sticky});
    check({tag, "_state_idle"}, {30'd0, dbg_state_o}, 32'd0);
  endtask

  initial begin
    // Reset state.
    #3;
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_req", {31'd0, bus_req_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_sticky", {31'd0, err_sticky_o}, 32'd0);
    check("rst_state", {30'd0, dbg_state_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Green load, two waiting cycles then ack 0xA5.
    run_txn(1'b1, 1'b0, 2'b01, 32'h40, 32'h0, 2, 0, 0, 8'hA5, 8'h00, 8'h00);
    check("ldg_beats", t_beats, 32'd1);
    check("ldg_sel", t_sel[0], 32'd1);
    check("ldg_we", t_we[0], 32'd0);
    check("ldg_addr", t_addr[0], 32'h40);
    check("ldg_rdata", t_rdata, 32'h0000A500);
    check("ldg_valid", t_valid, 32'd1);
    check("ldg_stall", t_stall, 32'd4);
    check_after("ldg", 1'b0);

    // Packed store, immediate acks.
    run_txn(1'b0, 1'b1, 2'b11, 32'h100, 32'h00332211, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    check("stp_beats", t_beats, 32'd3);
    check("stp_sel0", t_sel[0], 32'd0);
    check("stp_sel1", t_sel[1], 32'd1);
    check("stp_sel2", t_sel[2], 32'd2);
    check("stp_wd0", t_wd[0], 32'h11);
    check("stp_wd1", t_wd[1], 32'h22);
    check("stp_wd2", t_wd[2], 32'h33);
    check("stp_we", t_we[0] & t_we[1] & t_we[2], 32'd1);
    check("stp_addr2", t_addr[2], 32'h100);
    check("stp_valid", t_valid, 32'd0);
    check("stp_stall", t_stall, 32'd4);
    check_after("stp", 1'b0);

    // Packed load, acks 0x10, 0x20, 0x30 with mixed delays.
    run_txn(1'b1, 1'b0, 2'b11, 32'h200, 32'h0, 0, 1, 3, 8'h10, 8'h20, 8'h30);
    check("ldp_beats", t_beats, 32'd3);
    check("ldp_sel2", t_sel[2], 32'd2);
    check("ldp_rdata", t_rdata, 32'h00302010);
    check("ldp_valid", t_valid, 32'd1);
    check("ldp_stall", t_stall, 32'd8);
    check_after("ldp", 1'b0);

    // Read and write together behave as a write (blue channel).
    run_txn(1'b1, 1'b1, 2'b10, 32'h44, 32'h00770000, 1, 0, 0, 8'hEE, 8'h00, 8'h00);
    check("rw_sel", t_sel[0], 32'd2);
    check("rw_we", t_we[0], 32'd1);
    check("rw_wd", t_wd[0], 32'h77);
    check("rw_valid", t_valid, 32'd0);
    check("rw_rdata", t_end_rdata, 32'd0);
    check_after("rw", 1'b0);

    // Ack in the 15th waiting cycle (counter reaching TIMEOUT): ack wins.
    run_txn(1'b1, 1'b0, 2'b00, 32'h48, 32'h0, 14, 0, 0, 8'h5C, 8'h00, 8'h00);
    check("edge_err", t_err, 32'd0);
    check("edge_valid", t_valid, 32'd1);
    check("edge_rdata", t_rdata, 32'h5C);
    check("edge_stall", t_stall, 32'd16);
    check_after("edge", 1'b0);

    // No ack at all: timeout after 15 waiting cycles.
    run_txn(1'b1, 1'b0, 2'b11, 32'h4C, 32'h0, 0, 99, 0, 8'h99, 8'h00, 8'h00);
    check("to_err", t_err, 32'd1);
    check("to_valid", t_valid, 32'd0);
    check("to_req", t_end_req, 32'd0);
    check("to_rdata", t_end_rdata, 32'd0);
    check("to_stall", t_stall, 32'd17);
    check_after("to", 1'b1);

    // Reset during beat 1 (second beat) of a packed load.
    @(negedge clk);
    mem_read_i = 1'b1; rgb_i = 2'b11; addr_i = 32'h80;
    @(negedge clk);
    mem_read_i = 1'b0;
    bus_ack_i = 1'b1; bus_rdata_i = 8'h10;
    @(negedge clk);
    bus_ack_i = 1'b0;
    check("mid_sel", {30'd0, bus_sel_o}, 32'd1);
    check("mid_req", {31'd0, bus_req_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, bus_req_o}, 32'd0);
    check("mid_rst_stall", {31'd0, stall_o}, 32'd0);
    check("mid_rst_addr", bus_addr_o, 32'd0);
    check("mid_rst_sel", {30'd0, bus_sel_o}, 32'd0);
    check("mid_rst_rdata", rdata_o, 32'd0);
    check("mid_rst_pulses", {30'd0, rdata_valid_o, err_o}, 32'd0);
    check("mid_rst_sticky", {31'd0, err_sticky_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Next request restarts at beat 0.
    run_txn(1'b1, 1'b0, 2'b11, 32'h84, 32'h0, 0, 0, 0, 8'h01, 8'h02, 8'h03);
    check("post_sel0", t_sel[0], 32'd0);
    check("post_sel1", t_sel[1], 32'd1);
    check("post_sel2", t_sel[2], 32'd2);
    check("post_rdata", t_rdata, 32'h00030201);
    check_after("post", 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
